// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, command bytes and timing defaults
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } ps2_tx_state_e;

    localparam logic [7:0] CMD_SET_LED  = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] ACK_BYTE     = 8'hFA;

    // 100 us and 15 ms at a 50 MHz master clock
    localparam int DEFAULT_INHIBIT_CYCLES = 5000;
    localparam int DEFAULT_TIMEOUT_CYCLES = 750000;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// rtl/ps2_host_tx_if.sv - command byte handshake and status between client and transmitter
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;
    logic       busy;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_done, tx_error, busy
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_done, tx_error, busy
    );
endinterface

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - two-flop synchronizer for PS/2 clock/data with clock falling-edge pulse
module ps2_line_sync (
    input  logic master_clk,
    input  logic rst,
    input  logic clk_in,
    input  logic data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);
    logic clk_meta;
    logic data_meta;
    logic clk_prev;

    // Idle PS/2 lines are high, so reset to 1 to avoid a phantom edge after reset
    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= clk_in;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= data_in;
            data_sync <= data_meta;
        end
    end

    assign clk_fall = clk_prev & ~clk_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command transmitter (inhibit, RTS, shift, ack)
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEFAULT_INHIBIT_CYCLES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic            master_clk,
    input  logic            rst,
    ps2_host_tx_if.slave    tx_bus,
    input  logic            ps2_clk_in,
    input  logic            ps2_data_in,
    output logic            ps2_clk_oe,
    output logic            ps2_data_oe
);
    localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] START_AT     = 20'(INHIBIT_CYCLES - 2);
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_e state;
    logic [9:0]    frame;
    logic [19:0]   cyc_cnt;
    logic [3:0]    bit_cnt;
    logic          tx_ready_r;
    logic          tx_done_r;
    logic          tx_error_r;
    logic          busy_r;

    logic clk_sync;
    logic data_sync;
    logic clk_fall;
    logic counting;

    ps2_line_sync u_sync (
        .master_clk (master_clk),
        .rst        (rst),
        .clk_in     (ps2_clk_in),
        .data_in    (ps2_data_in),
        .clk_sync   (clk_sync),
        .data_sync  (data_sync),
        .clk_fall   (clk_fall)
    );

    // The same counter times the inhibit and, once the clock is released, the timeout
    assign counting = (state == ST_RTS) || (state == ST_SHIFT) ||
                      (state == ST_ACK) || (state == ST_WAIT_IDLE);

    always_ff @(posedge master_clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            frame       <= '0;
            cyc_cnt     <= '0;
            bit_cnt     <= '0;
            tx_ready_r  <= 1'b1;
            tx_done_r   <= 1'b0;
            tx_error_r  <= 1'b0;
            busy_r      <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
        end else begin
            tx_done_r  <= 1'b0;
            tx_error_r <= 1'b0;
            if (counting && cyc_cnt == TIMEOUT_LAST) begin
                tx_error_r  <= 1'b1;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                state       <= ST_IDLE;
            end else begin
                if (counting) begin
                    cyc_cnt <= cyc_cnt + 20'd1;
                end
                unique case (state)
                    ST_IDLE: begin
                        tx_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        if (tx_bus.tx_valid && tx_ready_r) begin
                            frame      <= {1'b1, odd_parity(tx_bus.tx_data), tx_bus.tx_data};
                            cyc_cnt    <= '0;
                            bit_cnt    <= '0;
                            tx_ready_r <= 1'b0;
                            busy_r     <= 1'b1;
                            ps2_clk_oe <= 1'b1;
                            state      <= ST_INHIBIT;
                        end
                    end
                    ST_INHIBIT: begin
                        cyc_cnt <= cyc_cnt + 20'd1;
                        if (cyc_cnt == START_AT) begin
                            ps2_data_oe <= 1'b1;
                        end
                        if (cyc_cnt == INHIBIT_LAST) begin
                            ps2_clk_oe <= 1'b0;
                            cyc_cnt    <= '0;
                            state      <= ST_RTS;
                        end
                    end
                    ST_RTS: begin
                        state <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        // Edge n presents frame bit n-1; the stop bit leaves the line released
                        if (clk_fall) begin
                            ps2_data_oe <= ~frame[bit_cnt];
                            bit_cnt     <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd9) begin
                                state <= ST_ACK;
                            end
                        end
                    end
                    ST_ACK: begin
                        if (clk_fall) begin
                            bit_cnt <= bit_cnt + 4'd1;
                            if (!data_sync) begin
                                state <= ST_WAIT_IDLE;
                            end else begin
                                tx_error_r  <= 1'b1;
                                ps2_clk_oe  <= 1'b0;
                                ps2_data_oe <= 1'b0;
                                state       <= ST_IDLE;
                            end
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (clk_sync && data_sync) begin
                            tx_done_r <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_bus.tx_ready = tx_ready_r;
    assign tx_bus.tx_done  = tx_done_r;
    assign tx_bus.tx_error = tx_error_r;
    assign tx_bus.busy     = busy_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INHIBIT = 5000;
    localparam int TIMEOUT = 3000;
    localparam int HALF    = 20;

    logic master_clk = 1'b0;
    logic rst = 1'b0;
    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic ps2_clk_oe;
    logic ps2_data_oe;
    wire  ps2_clk_pin  = ~(ps2_clk_oe | dev_clk_low);
    wire  ps2_data_pin = ~(ps2_data_oe | dev_data_low);

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    ps2_host_tx_if bus ();

    ps2_host_tx #(
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .master_clk  (master_clk),
        .rst         (rst),
        .tx_bus      (bus),
        .ps2_clk_in  (ps2_clk_pin),
        .ps2_data_in (ps2_data_pin),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 master_clk = ~master_clk;

    always @(negedge master_clk) begin
        if (bus.tx_done)  done_cnt++;
        if (bus.tx_error) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge master_clk);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        @(negedge master_clk);
    endtask

    task automatic wait_done(input string tag);
        int g = 0;
        while (!bus.tx_done && g < 200) begin
            @(negedge master_clk);
            g++;
        end
        chk(tag, {31'd0, bus.tx_done}, 32'd1);
    endtask

    // Device model: measures the inhibit, then clocks n_edges falling edges.
    // cap[0] is the start bit, cap[e] the bit read while the clock is low after edge e.
    task automatic dev_xfer(input int n_edges, input bit ack, output logic [10:0] cap,
                            output int inh_cnt, output int inh_data_hi, output logic inh_last);
        int g = 0;
        cap = '0;
        inh_cnt = 0;
        inh_data_hi = 0;
        inh_last = 1'b0;
        while (!ps2_clk_oe && g < 100) begin
            @(negedge master_clk);
            g++;
        end
        while (ps2_clk_oe && inh_cnt < 20000) begin
            inh_cnt++;
            if (ps2_data_oe) inh_data_hi++;
            inh_last = ps2_data_oe;
            @(negedge master_clk);
        end
        repeat (2 * HALF) @(negedge master_clk);
        cap[0] = ps2_data_pin;
        for (int e = 1; e <= n_edges; e++) begin
            if (e == 11 && ack) begin
                dev_data_low = 1'b1;
                repeat (2) @(negedge master_clk);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge master_clk);
            if (e <= 10) cap[e] = ps2_data_pin;
            if (e < n_edges || n_edges == 11) begin
                dev_clk_low = 1'b0;
                repeat (HALF) @(negedge master_clk);
            end
        end
        if (n_edges == 11) dev_data_low = 1'b0;
    endtask

    initial begin
        logic [10:0] cap;
        int inh_cnt;
        int inh_hi;
        logic inh_last;
        int g;
        int t;

        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        repeat (3) @(negedge master_clk);
        chk("rst_ready",   {31'd0, bus.tx_ready}, 32'd1);
        chk("rst_busy",    {31'd0, bus.busy},     32'd0);
        chk("rst_done",    {31'd0, bus.tx_done},  32'd0);
        chk("rst_error",   {31'd0, bus.tx_error}, 32'd0);
        chk("rst_clk_oe",  {31'd0, ps2_clk_oe},   32'd0);
        chk("rst_data_oe", {31'd0, ps2_data_oe},  32'd0);
        rst = 1'b1;
        repeat (2) @(negedge master_clk);

        // 0xED with ack
        send(CMD_SET_LED);
        bus.tx_valid = 1'b0;
        chk("ed_clk_oe_next", {31'd0, ps2_clk_oe}, 32'd1);
        chk("ed_busy", {31'd0, bus.busy}, 32'd1);
        dev_xfer(11, 1'b1, cap, inh_cnt, inh_hi, inh_last);
        chk("ed_frame", {21'd0, cap}, 32'h7DA);
        wait_done("ed_done_seen");
        chk("ed_ready_in_pulse", {31'd0, bus.tx_ready}, 32'd0);
        @(negedge master_clk);
        chk("ed_ready_after", {31'd0, bus.tx_ready}, 32'd1);
        chk("ed_busy_after",  {31'd0, bus.busy},     32'd0);
        chk("ed_done_1cyc",   {31'd0, bus.tx_done},  32'd0);
        repeat (3) @(negedge master_clk);
        chk("ed_done_cnt", done_cnt, 32'd1);
        chk("ed_err_cnt",  err_cnt,  32'd0);

        // 0x00: inhibit length and start-bit placement
        send(8'h00);
        bus.tx_valid = 1'b0;
        dev_xfer(11, 1'b1, cap, inh_cnt, inh_hi, inh_last);
        chk("inh_cycles",  inh_cnt, INHIBIT);
        chk("inh_data_hi", inh_hi,  32'd1);
        chk("inh_last",    {31'd0, inh_last}, 32'd1);
        chk("zero_frame",  {21'd0, cap}, 32'h600);
        wait_done("zero_done_seen");
        repeat (3) @(negedge master_clk);
        chk("zero_done_cnt", done_cnt, 32'd2);

        // 0x01 with no ack
        send(8'h01);
        bus.tx_valid = 1'b0;
        dev_xfer(11, 1'b0, cap, inh_cnt, inh_hi, inh_last);
        repeat (5) @(negedge master_clk);
        chk("nack_frame",   {21'd0, cap}, 32'h402);
        chk("nack_err_cnt", err_cnt,  32'd1);
        chk("nack_done",    done_cnt, 32'd2);
        chk("nack_clk_oe",  {31'd0, ps2_clk_oe},  32'd0);
        chk("nack_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        chk("nack_ready",   {31'd0, bus.tx_ready}, 32'd1);

        // silent device: timeout measured from clock release
        send(CMD_ECHO);
        bus.tx_valid = 1'b0;
        g = 0;
        while (ps2_clk_oe && g < 10000) begin
            @(negedge master_clk);
            g++;
        end
        chk("to_released", {31'd0, ps2_clk_oe}, 32'd0);
        t = 0;
        while (!bus.tx_error && t < TIMEOUT + 100) begin
            @(negedge master_clk);
            t++;
        end
        chk("to_cycles", t, TIMEOUT);
        @(negedge master_clk);
        chk("to_ready",   {31'd0, bus.tx_ready}, 32'd1);
        chk("to_busy",    {31'd0, bus.busy},     32'd0);
        chk("to_data_oe", {31'd0, ps2_data_oe},  32'd0);
        chk("to_err_cnt", err_cnt, 32'd2);

        // reset during edge 5 of 0xFF, then a full 0xFF
        send(CMD_RESET);
        bus.tx_valid = 1'b0;
        dev_xfer(5, 1'b1, cap, inh_cnt, inh_hi, inh_last);
        chk("rst_mid_busy",  {31'd0, bus.busy}, 32'd1);
        chk("rst_mid_frame", {26'd0, cap[5:0]}, 32'h3E);
        rst = 1'b0;
        #1;
        chk("rst_mid_clk_oe",  {31'd0, ps2_clk_oe},  32'd0);
        chk("rst_mid_data_oe", {31'd0, ps2_data_oe}, 32'd0);
        chk("rst_mid_ready",   {31'd0, bus.tx_ready}, 32'd1);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge master_clk);
        rst = 1'b1;
        @(negedge master_clk);
        chk("rst_mid_ready_after", {31'd0, bus.tx_ready}, 32'd1);
        chk("rst_mid_no_done", done_cnt, 32'd2);
        chk("rst_mid_no_err",  err_cnt,  32'd2);
        send(CMD_RESET);
        bus.tx_valid = 1'b0;
        dev_xfer(11, 1'b1, cap, inh_cnt, inh_hi, inh_last);
        chk("ff_frame", {21'd0, cap}, 32'h7FE);
        wait_done("ff_done_seen");
        repeat (3) @(negedge master_clk);
        chk("ff_done_cnt", done_cnt, 32'd3);

        // tx_valid held with a new byte during a transfer
        send(BREAK_PREFIX);
        bus.tx_data = ACK_BYTE;
        dev_xfer(11, 1'b1, cap, inh_cnt, inh_hi, inh_last);
        chk("hold_first_frame", {21'd0, cap}, 32'h7E0);
        wait_done("hold_first_done");
        g = 0;
        while (!ps2_clk_oe && g < 20) begin
            @(negedge master_clk);
            g++;
        end
        chk("hold_second_accept", {31'd0, ps2_clk_oe}, 32'd1);
        bus.tx_valid = 1'b0;
        dev_xfer(11, 1'b1, cap, inh_cnt, inh_hi, inh_last);
        chk("hold_second_frame", {21'd0, cap}, 32'h7F4);
        wait_done("hold_second_done");
        repeat (3) @(negedge master_clk);
        chk("hold_done_cnt", done_cnt, 32'd5);
        chk("hold_err_cnt",  err_cnt,  32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: the write path to the keyboard, complementing the existing PS/2 receive block on the same two open-drain lines. It accepts one command byte per valid/ready handshake, performs the inhibit/request-to-send sequence, and shifts out start, 8 data bits (LSB first), odd parity and stop on device-generated clock edges. It then checks the device acknowledge bit. Used by the paint top level to send LED-set (0xED), reset (0xFF) and similar commands. The receiver keeps listening on the same pins.

## Interface
- INHIBIT_CYCLES, 5000: clock-low hold before request-to-send (100 µs at 50 MHz).
- TIMEOUT_CYCLES, 750000: max cycles from clock release to ack/idle (15 ms at 50 MHz).
- master_clk  in  1  system clock, 50 MHz.
- rst  in  1  reset, asynchronous, active-low.
- tx_data  in  8  command byte; sampled on accept.
- tx_valid  in  1  request to send tx_data.
- tx_ready  out  1  high only in IDLE; accept = tx_valid & tx_ready on a rising edge.
- tx_done  out  1  one-cycle pulse: byte sent and acknowledged.
- tx_error  out  1  one-cycle pulse: timeout or missing ack.
- busy  out  1  high in every state except IDLE; top level uses it to mask receiver datafetched.
- ps2_clk_in, ps2_data_in  in  1 each  raw pin reads (asynchronous).
- ps2_clk_oe, ps2_data_oe  out  1 each  1 = drive pin low, 0 = release (pin = oe ? 0 : z at top).

## Operation
- Inputs pass through a 2-flop synchronizer; falling edge = synchronized clock history 2'b10.
- States: IDLE, INHIBIT, RTS, SHIFT, ACK, WAIT_IDLE.
- IDLE: both oe = 0, tx_ready = 1. On accept: latch byte, compute parity = ~^tx_data, build 10-bit frame {stop=1, parity, data[7:0]}, clear counters, go to INHIBIT.
- INHIBIT: ps2_clk_oe = 1 for exactly INHIBIT_CYCLES cycles. Assert ps2_data_oe = 1 (start bit) on the final inhibit cycle. Then go to RTS.
- RTS: ps2_clk_oe = 0, ps2_data_oe held 1. Timeout counter starts. Go to SHIFT.
- SHIFT: on each detected falling edge, present the next frame bit (ps2_data_oe = ~bit).
  - Edges 1–8: data[0..7].
  - Edge 9: parity.
  - Edge 10: stop (released).
  - After edge 10, go to ACK.
- ACK: on the next falling edge, sample synchronized data. If 0, go to WAIT_IDLE; if 1, pulse tx_error and go to IDLE.
- WAIT_IDLE: wait until synchronized clock and data are both 1, then pulse tx_done and go to IDLE.
- Timeout: a 20-bit counter runs in RTS, SHIFT, ACK and WAIT_IDLE. When it reaches TIMEOUT_CYCLES: pulse tx_error, release both lines, go to IDLE.
- Edge counter is 4 bits and never exceeds 11.
- tx_valid outside IDLE is ignored; no queueing.

## Timing
- Reset values: state IDLE, ps2_clk_oe = 0, ps2_data_oe = 0, tx_ready = 1, busy = 0, tx_done = 0, tx_error = 0, counters 0.
- Reset mid-operation releases both lines immediately (asynchronously). The transfer is abandoned with no done/error pulse.
- Accept → ps2_clk_oe high: next rising edge.
- Falling edge on pin → ps2_data_oe update: 3 master_clk cycles (2 sync + 1 register). This is well inside the device's ~40 µs half-period.
- tx_done/tx_error assert for exactly one cycle. tx_ready returns to 1 on the cycle after the pulse.
- Timeout and ACK decision in the same cycle: timeout wins, so tx_error pulses once.
- All outputs are registered.

## Structure
- Shared package ps2_pkg:
  - State enum.
  - Command constants: CMD_SET_LED = 8'hED, CMD_RESET = 8'hFF, CMD_ECHO = 8'hEE, BREAK_PREFIX = 8'hF0, ACK_BYTE = 8'hFA.
  - Default INHIBIT_CYCLES and TIMEOUT_CYCLES.
- One sub-module, ps2_line_sync: 2-flop synchronizer for clock and data plus falling-edge pulse. It is reusable by the receiver.

## Test plan
- Send 0xED with a device model clocking at 12.5 kHz and acking → data pins show 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Exactly one tx_done pulse; tx_ready = 1 afterwards.
- Measure INHIBIT: send 0x00 → ps2_clk_oe high for exactly 5000 cycles, ps2_data_oe rising on the last one. Parity bit on the line = 1.
- NACK: device leaves data high at edge 11 while sending 0x01 (parity 0) → one tx_error pulse, no tx_done, both oe = 0.
- No device clocks after RTS → tx_error exactly TIMEOUT_CYCLES cycles after the clock release; state returns to IDLE.
- Assert rst low at edge 5 of a 0xFF transfer → both oe drop to 0 the same instant. No pulses. After rst is released, tx_ready = 1 and the next 0xFF completes.
- tx_valid held high with a different byte during a transfer → ignored. Only the first byte appears on the line, then the second is accepted once back in IDLE.
